// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers: picks a pending requester, latches its byte,
// pulses tx_start and follows tx_busy. Define UART_TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic                        timeout,
    output logic [1:0]                  state_dbg
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

    // Handshake: req[i] is held with a stable byte until gnt[i] pulses for one cycle; the byte is
    // captured on that edge, and a req still high the cycle after gnt is taken as a new byte.
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t              state, state_nx;
    logic [TW-1:0]       timer;
    logic                found;
    logic [IDW-1:0]      win;
    logic [DATA_W-1:0]   win_data;
    logic                grant_fire;
    logic                expire;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = IDW'(i);
            end
        end
    end
`else
    logic [IDW-1:0] rr_ptr;
    logic [IDW:0]   cand;

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ; first pending requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ))
                cand = cand - (IDW+1)'(NUM_REQ);
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_fire)
            rr_ptr <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
    end
`endif

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDW'(i))
                win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign grant_fire = (state == IDLE) && !tx_busy && found;
    // tx_busy takes precedence over an expiry landing in the same cycle.
    assign expire     = (state == WAIT_ACK) && !tx_busy && (timer == T_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (grant_fire) state_nx = START;
            START:     state_nx = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) state_nx = WAIT_DONE;
                       else if (expire) state_nx = IDLE;
            WAIT_DONE: if (!tx_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            grant_id <= '0;
            timeout  <= 1'b0;
            timer    <= '0;
        end else begin
            gnt      <= '0;
            tx_start <= (state == START);
            timeout  <= expire;
            if (grant_fire) begin
                gnt      <= NUM_REQ'(1) << win;
                tx_data  <= win_data;
                grant_id <= win;
            end
            if (state == START)
                timer <= '0;
            else if (state == WAIT_ACK)
                timer <= timer + TW'(1);
        end
    end

    assign arb_busy  = (state != IDLE);
    assign state_dbg = state;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: grant-age model checked every cycle, plus directed literal checks.
// Honours UART_TX_ARB_FIXED_PRIO_EN in both model and expectations.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic [W-1:0]   tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           timeout;
    logic [1:0]     state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
        .arb_busy(arb_busy), .timeout(timeout), .state_dbg(state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expired(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait bound expired", name);
    endtask

    // Transmitter: busy from the cycle after tx_start for frame_len cycles.
    bit tx_en = 1'b1;
    int frame_len = 100;
    int rem = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rem = 0;
            tx_busy = 1'b0;
        end else begin
            if (tx_en && tx_start) rem = frame_len;
            #1;
            if (rem > 0) begin
                tx_busy = 1'b1;
                rem--;
            end else
                tx_busy = 1'b0;
        end
    end

    // Reference model: tracks the age of the current grant (0 = gnt cycle, 1 = tx_start cycle).
    int m_rr, m_age, e_id, w;
    bit m_active, m_acked;
    logic [N-1:0] e_gnt;
    logic e_start, e_to;
    logic [W-1:0] e_data;

    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (r[k]) return k;
`else
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rr = 0; m_age = 0; m_active = 0; m_acked = 0;
            e_gnt = '0; e_start = 0; e_to = 0; e_data = '0; e_id = 0;
        end else begin
            e_gnt = '0; e_start = 0; e_to = 0;
            if (!m_active) begin
                if (!tx_busy && req != '0) begin
                    w = pick(req, m_rr);
                    e_gnt[w] = 1'b1;
                    e_id = w;
                    e_data = req_data[w*W +: W];
                    m_rr = (w + 1) % N;
                    m_active = 1; m_acked = 0; m_age = 0;
                end
            end else if (m_age == 0) begin
                e_start = 1;
                m_age = 1;
            end else if (m_acked) begin
                if (!tx_busy) m_active = 0;
            end else if (tx_busy) begin
                m_acked = 1;
            end else if (m_age == TO) begin
                m_active = 0;
                e_to = 1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        check("gnt", gnt, e_gnt);
        check("tx_start", tx_start, e_start);
        check("timeout", timeout, e_to);
        check("arb_busy", arb_busy, m_active);
        check("tx_data", tx_data, e_data);
        check("grant_id", grant_id, e_id);
        check("exclusive", $onehot0({|gnt, tx_start, timeout}), 1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(output int id);
        id = -1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (gnt != '0) begin
                for (int j = 0; j < N; j++) if (gnt[j]) id = j;
                check("gnt_onehot", $countones(gnt), 1);
                break;
            end
        end
        if (id < 0) expired("wait_gnt");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!arb_busy && !tx_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) expired("wait_idle");
    endtask

    int id, fall_a, fall_b, cyc, n;
    logic [W-1:0] e;

    initial begin
        req = '0; req_data = '0; reset = 1'b1;
        tick(); tick();
        check("rst_gnt", gnt, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_grant_id", grant_id, 0);
        reset = 1'b0;

        // single request, 100-cycle frame
        req_data[7:0] = 8'h41;
        tick(); req = 4'b0001;
        tick(); check("single_gnt", gnt, 4'b0001);
        tick(); req = '0;
        check("single_start", tx_start, 1);
        check("single_data", tx_data, 8'h41);
        cyc = 2; fall_a = -1; fall_b = -1;
        for (int k = 0; k < 300; k++) begin
            tick(); cyc++;
            if (fall_b < 0 && !tx_busy) fall_b = cyc;
            if (!arb_busy) begin
                fall_a = cyc;
                break;
            end
        end
        check("busy_fall_cycle", fall_b, 103);
        check("arb_fall_lag", fall_a - fall_b, 1);

        // reset during WAIT_DONE
        tick(); req = 4'b0001;
        wait_gnt(id);
        tick(); req = '0;
        for (int k = 0; k < 10; k++) tick();
        check("pre_reset_busy", arb_busy, 1);
        #1 reset = 1'b1;
        #1;
        check("async_arb_busy", arb_busy, 0);
        check("async_tx_data", tx_data, 0);
        check("async_grant_id", grant_id, 0);
        tick(); reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_reset_idle", arb_busy, 0);
        end

        // continuous requests, short frames
        frame_len = 5;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'h10 + 8'(i);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        req = 4'b1010;
        exp_q = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
`else
        req = 4'b1111;
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
`endif
        for (int k = 0; k < 5; k++) begin
            wait_gnt(id);
            e = exp_q.pop_front();
            check("rr_order", id, e);
            check("rr_data", tx_data, 8'h10 + e);
        end
        req = '0;
        wait_idle();

        // wrap and skip from rr_ptr = 3
        reset = 1'b1; tick(); reset = 1'b0;
        req = 4'b0100;
        wait_gnt(id);
        check("wrap_setup", id, 2);
        tick(); req = '0;
        wait_idle();
        req = 4'b0101;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        exp_q = '{8'd0, 8'd0, 8'd0};
`else
        exp_q = '{8'd0, 8'd2, 8'd0};
`endif
        for (int k = 0; k < 3; k++) begin
            wait_gnt(id);
            e = exp_q.pop_front();
            check("wrap_order", id, e);
        end
        req = '0;
        wait_idle();

        // acknowledge timeout with transmitter silent
        tx_en = 1'b0;
        req = 4'b0010;
        wait_gnt(id);
        check("to_gnt", id, 1);
        tick(); req = '0;
        check("to_start", tx_start, 1);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick(); n++;
            if (timeout) break;
        end
        check("to_delay", n, 16);
        check("to_idle", arb_busy, 0);
        req = 4'b0110;
        wait_gnt(id);
`ifdef UART_TX_ARB_FIXED_PRIO_EN
        check("to_rr_kept", id, 1);
`else
        check("to_rr_kept", id, 2);
`endif
        tick(); req = '0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        expired("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
